// File: rtl/filt_job_sequencer.sv
// Round-robin job sequencer sharing one filter address counter among NREQ requesters.
// Optional performance counters are compiled in when FILT_SEQ_PERF_EN is defined.
module filt_job_sequencer #(
    parameter int NREQ = 4,
    parameter int AW   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   req_size,
    input  logic [NREQ*AW-1:0]   req_base,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      job_done,
    output logic                 busy,
    output logic                 cnt_enable,
    output logic                 cnt_pause,
    output logic [31:0]          cnt_filesize,
    input  logic [31:0]          cnt_count,
    input  logic                 cnt_done,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [AW-1:0]        mem_addr,
    output logic [1:0]           dbg_state
`ifdef FILT_SEQ_PERF_EN
    ,
    output logic [31:0]          perf_cycles,
    output logic [31:0]          perf_stalls
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [PW-1:0]       r_rr_ptr;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_job_done;
    logic                r_busy;
    logic                r_cnt_enable;
    logic [31:0]         r_size;
    logic [AW-1:0]       r_base;
    logic                r_mem_valid;
    logic [AW-1:0]       r_mem_addr;
    logic [31:0]         r_last_cnt;

    logic                w_found;
    logic [PW-1:0]       w_winner;
    logic [PW:0]         w_idx;
    logic [PW-1:0]       w_ptr_nxt;
    logic [NREQ-1:0]     w_onehot;
    logic [31:0]         w_sel_size;
    logic [AW-1:0]       w_sel_base;
    logic [AW-1:0]       w_cnt_ext;
    logic [AW-1:0]       w_addr;
    logic                w_hs;
    logic                w_slot_free;
    logic                w_capture;
    logic                w_finish;

    // Rotating first-fit search starting at the round-robin pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (PW+1)'(i);
            if (w_idx >= (PW+1)'(NREQ)) begin
                w_idx = w_idx - (PW+1)'(NREQ);
            end
            if (!w_found && req[w_idx[PW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        w_ptr_nxt  = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + PW'(1);
        w_onehot   = '0;
        w_onehot[w_winner] = 1'b1;
        w_sel_size = '0;
        w_sel_base = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == PW'(i)) begin
                w_sel_size = req_size[32*i +: 32];
                w_sel_base = req_base[AW*i +: AW];
            end
        end
    end

    generate
        if (AW > 32) begin : g_cnt_wide
            assign w_cnt_ext = {{(AW-32){1'b0}}, cnt_count};
        end else if (AW == 32) begin : g_cnt_equal
            assign w_cnt_ext = cnt_count;
        end else begin : g_cnt_narrow
            assign w_cnt_ext = cnt_count[AW-1:0];
        end
    endgenerate

    assign w_addr = r_base + w_cnt_ext;

    // Valid/ready on the memory port: an address is transferred in a cycle where
    // mem_valid and mem_ready are both high; mem_valid and mem_addr hold until then,
    // and a new count may be registered in the same cycle the old one is accepted.
    assign w_hs        = r_mem_valid & mem_ready;
    assign w_slot_free = ~r_mem_valid | w_hs;
    assign w_capture   = (r_state == S_RUN) && (cnt_count != '1) &&
                         (cnt_count != r_last_cnt) && w_slot_free;
    assign w_finish    = cnt_done && (r_last_cnt == (r_size - 32'd1)) && w_slot_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_found) w_next = S_LOAD;
            S_LOAD: w_next = (r_size == 32'd0) ? S_DONE : S_RUN;
            S_RUN:  if (w_finish) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_gnt        <= '0;
            r_job_done   <= '0;
            r_busy       <= 1'b0;
            r_cnt_enable <= 1'b0;
            r_size       <= '0;
            r_base       <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_last_cnt   <= '1;
        end else begin
            r_job_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt      <= w_onehot;
                        r_busy     <= 1'b1;
                        r_size     <= w_sel_size;
                        r_base     <= w_sel_base;
                        r_rr_ptr   <= w_ptr_nxt;
                        r_last_cnt <= '1;
                    end
                end
                S_LOAD: begin
                    if (r_size == 32'd0) begin
                        r_job_done <= r_gnt;
                    end else begin
                        r_cnt_enable <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_finish) begin
                        r_cnt_enable <= 1'b0;
                        r_mem_valid  <= 1'b0;
                        r_job_done   <= r_gnt;
                    end else if (w_capture) begin
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= w_addr;
                        r_last_cnt  <= cnt_count;
                    end else if (w_hs) begin
                        r_mem_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_gnt  <= '0;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign gnt          = r_gnt;
    assign job_done     = r_job_done;
    assign busy         = r_busy;
    assign cnt_enable   = r_cnt_enable;
    assign cnt_pause    = r_mem_valid & ~mem_ready;
    assign cnt_filesize = r_size;
    assign mem_valid    = r_mem_valid;
    assign mem_addr     = r_mem_addr;
    assign dbg_state    = r_state;

`ifdef FILT_SEQ_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;

    // Saturating counters of RUN cycles and of RUN cycles stalled by memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (r_state == S_LOAD) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (r_state == S_RUN) begin
            if (r_perf_cycles != '1) r_perf_cycles <= r_perf_cycles + 32'd1;
            if (cnt_pause && (r_perf_stalls != '1)) r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stalls = r_perf_stalls;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
